pipeline_ctrl_shadow_commit: RTL

Frame-synchronous configuration controller for the compositing pipeline. It decodes a byte-oriented command stream from the SPI byte receiver into shadow control registers, then copies them into the active registers that drive the pipeline's `ctrl_*` inputs only on the last visible pixel of a frame. Mode, scale, offset and clip changes therefore never tear mid-frame. It also returns a status byte to the SPI side.

---
 rtl/pipeline_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_ctrl_regbank.sv | 85 ++++++++
 rtl/pipeline_ctrl_shadow_commit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the frame-synchronous pipeline control block:
// opcodes, decoder states, status-byte layout and payload-length helpers.
package pipeline_ctrl_pkg;

    localparam logic [7:0] OP_SET_MODE        = 8'h01;
    localparam logic [7:0] OP_SET_OFFSET_X    = 8'h02;
    localparam logic [7:0] OP_SET_OFFSET_Y    = 8'h03;
    localparam logic [7:0] OP_SET_CLIP_LEFT   = 8'h04;
    localparam logic [7:0] OP_SET_CLIP_RIGHT  = 8'h05;
    localparam logic [7:0] OP_SET_CLIP_TOP    = 8'h06;
    localparam logic [7:0] OP_SET_CLIP_BOTTOM = 8'h07;
    localparam logic [7:0] OP_COMMIT          = 8'h08;
    localparam logic [7:0] OP_CLEAR_ERR       = 8'h09;
    localparam logic [7:0] OP_ABORT           = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } dec_state_t;

    localparam int RESP_PENDING_BIT = 7;
    localparam int RESP_ERR_BIT     = 6;
    localparam int RESP_STATE_LSB   = 4;
    localparam int RESP_FCNT_LSB    = 0;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op >= OP_SET_MODE) && (op <= OP_ABORT);
    endfunction

    function automatic logic [1:0] payload_len(input logic [7:0] op);
        case (op)
            OP_SET_MODE: return 2'd1;
            OP_SET_OFFSET_X, OP_SET_OFFSET_Y,
            OP_SET_CLIP_LEFT, OP_SET_CLIP_RIGHT,
            OP_SET_CLIP_TOP, OP_SET_CLIP_BOTTOM: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_ctrl_regbank.sv
// Shadow/active control register pair: the decoder writes shadow, frame-end
// commits copy shadow into active, and abort reloads shadow from active.
module pipeline_ctrl_regbank
    import pipeline_ctrl_pkg::*;
#(
    parameter int PRECISION = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_op,
    input  logic [PRECISION:0]          wr_data,
    input  logic                        commit,
    input  logic                        abort,
    output logic [1:0]                  ctrl_overlay_mode,
    output logic [1:0]                  ctrl_fg_scale,
    output logic signed [PRECISION:0]   ctrl_fg_offset_x,
    output logic signed [PRECISION:0]   ctrl_fg_offset_y,
    output logic [PRECISION-1:0]        ctrl_fg_clip_left,
    output logic [PRECISION-1:0]        ctrl_fg_clip_right,
    output logic [PRECISION-1:0]        ctrl_fg_clip_top,
    output logic [PRECISION-1:0]        ctrl_fg_clip_bottom
);

    typedef struct packed {
        logic [1:0]                mode;
        logic [1:0]                scale;
        logic signed [PRECISION:0] off_x;
        logic signed [PRECISION:0] off_y;
        logic [PRECISION-1:0]      clip_l;
        logic [PRECISION-1:0]      clip_r;
        logic [PRECISION-1:0]      clip_t;
        logic [PRECISION-1:0]      clip_b;
    } ctrl_regs_t;

    ctrl_regs_t shadow_q, shadow_d;
    ctrl_regs_t active_q, active_d;

    // Commit reads shadow_q, so a write landing on the same edge reaches
    // active only at the following commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (commit) begin
            active_d = shadow_q;
        end
        if (abort) begin
            shadow_d = active_q;
        end else if (wr_en) begin
            case (wr_op)
                OP_SET_MODE: begin
                    shadow_d.mode  = wr_data[1:0];
                    shadow_d.scale = wr_data[3:2];
                end
                OP_SET_OFFSET_X:    shadow_d.off_x  = wr_data;
                OP_SET_OFFSET_Y:    shadow_d.off_y  = wr_data;
                OP_SET_CLIP_LEFT:   shadow_d.clip_l = wr_data[PRECISION-1:0];
                OP_SET_CLIP_RIGHT:  shadow_d.clip_r = wr_data[PRECISION-1:0];
                OP_SET_CLIP_TOP:    shadow_d.clip_t = wr_data[PRECISION-1:0];
                OP_SET_CLIP_BOTTOM: shadow_d.clip_b = wr_data[PRECISION-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign ctrl_overlay_mode   = active_q.mode;
    assign ctrl_fg_scale       = active_q.scale;
    assign ctrl_fg_offset_x    = active_q.off_x;
    assign ctrl_fg_offset_y    = active_q.off_y;
    assign ctrl_fg_clip_left   = active_q.clip_l;
    assign ctrl_fg_clip_right  = active_q.clip_r;
    assign ctrl_fg_clip_top    = active_q.clip_t;
    assign ctrl_fg_clip_bottom = active_q.clip_b;

endmodule

// File: rtl/pipeline_ctrl_shadow_commit.sv
// SPI command decoder feeding shadow control registers, committed to the
// active pipeline controls only at the last visible pixel of a frame.
module pipeline_ctrl_shadow_commit
    import pipeline_ctrl_pkg::*;
#(
    parameter int PRECISION    = 11,
    parameter int RESOLUTION_X = 800,
    parameter int RESOLUTION_Y = 600
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  cmd_byte,
    input  logic                        cmd_byte_valid,
    input  logic                        cmd_txn_end,
    input  logic [PRECISION-1:0]        pixel_x,
    input  logic [PRECISION-1:0]        pixel_y,
    input  logic                        output_enable,
    output logic [7:0]                  resp_byte,
    output logic [1:0]                  ctrl_overlay_mode,
    output logic [1:0]                  ctrl_fg_scale,
    output logic signed [PRECISION:0]   ctrl_fg_offset_x,
    output logic signed [PRECISION:0]   ctrl_fg_offset_y,
    output logic [PRECISION-1:0]        ctrl_fg_clip_left,
    output logic [PRECISION-1:0]        ctrl_fg_clip_right,
    output logic [PRECISION-1:0]        ctrl_fg_clip_top,
    output logic [PRECISION-1:0]        ctrl_fg_clip_bottom,
    output logic                        ctrl_committed
);

    // Only the first-byte bits that survive truncation to PRECISION+1 are kept.
    localparam int HI_W = PRECISION - 7;
    localparam logic [PRECISION-1:0] LAST_X = PRECISION'(RESOLUTION_X - 1);
    localparam logic [PRECISION-1:0] LAST_Y = PRECISION'(RESOLUTION_Y - 1);

    dec_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        op_q, op_d;
    logic [HI_W-1:0]   payload_hi_q, payload_hi_d;
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic [3:0]        frame_cnt_q, frame_cnt_d;
    logic              committed_q, committed_d;

    logic              frame_end;
    logic              commit_fire;
    logic              wr_en;
    logic              do_abort;
    logic [PRECISION:0] wr_data;

    assign frame_end   = output_enable && (pixel_x == LAST_X) && (pixel_y == LAST_Y);
    assign commit_fire = frame_end && pending_q;
    assign wr_data     = {payload_hi_q, cmd_byte};

    // A byte arriving with the transaction-end strobe is decoded first, so the
    // end-of-transaction check looks at the post-byte state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        payload_hi_d = payload_hi_q;
        pending_d    = pending_q;
        err_d        = err_q;
        wr_en        = 1'b0;
        do_abort     = 1'b0;

        if (commit_fire) begin
            pending_d = 1'b0;
        end

        if (cmd_byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!is_known_op(cmd_byte)) begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end else if (payload_len(cmd_byte) != 2'd0) begin
                        op_d    = cmd_byte;
                        cnt_d   = payload_len(cmd_byte);
                        state_d = ST_PAYLOAD;
                    end else begin
                        case (cmd_byte)
                            OP_COMMIT:    pending_d = 1'b1;
                            OP_CLEAR_ERR: err_d     = 1'b0;
                            OP_ABORT: begin
                                pending_d = 1'b0;
                                do_abort  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    payload_hi_d = cmd_byte[HI_W-1:0];
                    if (cnt_q == 2'd1) begin
                        wr_en   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                ST_DISCARD: ;
                default: state_d = ST_IDLE;
            endcase
        end

        if (cmd_txn_end) begin
            if (state_d == ST_PAYLOAD) begin
                err_d = 1'b1;
            end
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        frame_cnt_d = frame_end ? frame_cnt_q + 4'd1 : frame_cnt_q;
        committed_d = commit_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            payload_hi_q <= '0;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
            committed_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            payload_hi_q <= payload_hi_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
            committed_q  <= committed_d;
        end
    end

    always_comb begin
        resp_byte                               = '0;
        resp_byte[RESP_PENDING_BIT]             = pending_q;
        resp_byte[RESP_ERR_BIT]                 = err_q;
        resp_byte[RESP_STATE_LSB +: 2]          = state_q;
        resp_byte[RESP_FCNT_LSB +: 4]           = frame_cnt_q;
    end

    assign ctrl_committed = committed_q;

    pipeline_ctrl_regbank #(
        .PRECISION (PRECISION)
    ) u_regbank (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_en               (wr_en),
        .wr_op               (op_q),
        .wr_data             (wr_data),
        .commit              (commit_fire),
        .abort               (do_abort),
        .ctrl_overlay_mode   (ctrl_overlay_mode),
        .ctrl_fg_scale       (ctrl_fg_scale),
        .ctrl_fg_offset_x    (ctrl_fg_offset_x),
        .ctrl_fg_offset_y    (ctrl_fg_offset_y),
        .ctrl_fg_clip_left   (ctrl_fg_clip_left),
        .ctrl_fg_clip_right  (ctrl_fg_clip_right),
        .ctrl_fg_clip_top    (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom)
    );

endmodule
